// File: rtl/sdram_device_emu.sv
// SDR SDRAM device emulator: command decode, per-bank rows, CAS pipeline.
// Optional protocol checker on `err` enabled by SDRAM_EMU_CHECK_EN.
module sdram_device_emu #(
  parameter int BANK_WIDTH     = 2,
  parameter int ROW_WIDTH      = 13,
  parameter int COL_WIDTH      = 9,
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clock_enable,
  input  logic                  cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [BANK_WIDTH-1:0] bank_addr,
  input  logic [ROW_WIDTH-1:0]  addr,
  input  logic [15:0]           dq_in,
  output logic [15:0]           dq_out,
  output logic                  dq_oe,
  input  logic                  data_mask_low,
  input  logic                  data_mask_high,
  output logic                  ready,
  output logic [15:0]           refresh_count,
  output logic                  err
);

  localparam int NB    = 1 << BANK_WIDTH;
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  logic       cmd_en;
  logic [2:0] cmd;
  logic       is_act, is_rd, is_wr;
  logic       is_pre, is_ref, is_mrs;

  assign cmd_en = clock_enable & ~cs_n;
  assign cmd    = {ras_n, cas_n, we_n};

  always_comb begin
    is_act = 1'b0;
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    is_pre = 1'b0;
    is_ref = 1'b0;
    is_mrs = 1'b0;
    if (cmd_en) begin
      unique case (cmd)
        3'b011:  is_act = 1'b1;
        3'b101:  is_rd  = 1'b1;
        3'b100:  is_wr  = 1'b1;
        3'b010:  is_pre = 1'b1;
        3'b001:  is_ref = 1'b1;
        3'b000:  is_mrs = 1'b1;
        default: ;
      endcase
    end
  end

  logic [NB-1:0]        bank_open;
  logic [ROW_WIDTH-1:0] bank_row [NB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_open <= '0;
      for (int i = 0; i < NB; i++) bank_row[i] <= '0;
    end else begin
      if (is_act) begin
        bank_open[bank_addr] <= 1'b1;
        bank_row[bank_addr]  <= addr;
      end
      if (is_pre) begin
        if (addr[10]) bank_open <= '0;
        else          bank_open[bank_addr] <= 1'b0;
      end
      // A10 on a column command closes the bank afterwards
      if ((is_rd | is_wr) & addr[10])
        bank_open[bank_addr] <= 1'b0;
    end
  end

  logic [MEM_ADDR_WIDTH-1:0] word_idx;

  assign word_idx = MEM_ADDR_WIDTH'({bank_addr, bank_row[bank_addr],
                                     addr[COL_WIDTH-1:0]});

  logic [7:0]  mem_lo [DEPTH];
  logic [7:0]  mem_hi [DEPTH];
  logic [15:0] rd_word;

  always_ff @(posedge clk) begin
    if (is_wr & ~data_mask_low)  mem_lo[word_idx] <= dq_in[7:0];
    if (is_wr & ~data_mask_high) mem_hi[word_idx] <= dq_in[15:8];
    if (is_rd) rd_word <= {mem_hi[word_idx], mem_lo[word_idx]};
  end

  logic cl2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cl2           <= 1'b0;
      ready         <= 1'b0;
      refresh_count <= '0;
    end else begin
      if (is_mrs) begin
        cl2   <= (addr[6:4] == 3'd2);
        ready <= 1'b1;
      end
      if (is_ref) refresh_count <= refresh_count + 16'd1;
    end
  end

  // Each beat carries the latency in force when its READ was sampled
  logic        s1_vld, s1_cl2;
  logic        s2_vld;
  logic [15:0] s2_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_cl2  <= 1'b0;
      s2_vld  <= 1'b0;
      s2_data <= '0;
      dq_oe   <= 1'b0;
      dq_out  <= '0;
    end else begin
      s1_vld  <= is_rd;
      s1_cl2  <= cl2;
      s2_vld  <= s1_vld & ~s1_cl2;
      s2_data <= rd_word;
      dq_oe   <= s2_vld | (s1_vld & s1_cl2);
      if (s2_vld)
        dq_out <= s2_data;
      else if (s1_vld & s1_cl2)
        dq_out <= rd_word;
    end
  end

`ifdef SDRAM_EMU_CHECK_EN
  logic viol;

  always_comb begin
    viol = ((is_rd | is_wr) & ~bank_open[bank_addr])
         | (is_act & bank_open[bank_addr])
         | ((is_mrs | is_ref) & (|bank_open))
         | (~ready & (is_act | is_rd | is_wr))
         | (is_mrs & (addr[2:0] != 3'b000))
         | (is_wr & dq_oe);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (viol) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_device_emu.sv
// Bench for sdram_device_emu: directed commands, read-beat scoreboard.
// Expected read data and sample edges are queued at issue time.
module tb_sdram_device_emu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clock_enable = 1'b1;
  logic        cs_n = 1'b1;
  logic        ras_n = 1'b1;
  logic        cas_n = 1'b1;
  logic        we_n = 1'b1;
  logic [1:0]  bank_addr = '0;
  logic [12:0] addr = '0;
  logic [15:0] dq_in = '0;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        data_mask_low = 1'b0;
  logic        data_mask_high = 1'b0;
  logic        ready;
  logic [15:0] refresh_count;
  logic        err;

`ifdef SDRAM_EMU_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  sdram_device_emu dut (
    .clk            (clk),
    .rst            (rst),
    .clock_enable   (clock_enable),
    .cs_n           (cs_n),
    .ras_n          (ras_n),
    .cas_n          (cas_n),
    .we_n           (we_n),
    .bank_addr      (bank_addr),
    .addr           (addr),
    .dq_in          (dq_in),
    .dq_out         (dq_out),
    .dq_oe          (dq_oe),
    .data_mask_low  (data_mask_low),
    .data_mask_high (data_mask_high),
    .ready          (ready),
    .refresh_count  (refresh_count),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          samp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cl_m = 3;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller samples at the edge that ends the cycle with dq_oe high
  always @(negedge clk) begin
    exp_t e;
    if (dq_oe === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: got %h at edge %0d, want no beat",
                 dq_out, cyc + 1);
      end else begin
        e = q.pop_front();
        if (dq_out !== e.data || (cyc + 1) != e.samp) begin
          n_bad++;
          $display("FAIL read_beat: got %h at edge %0d, want %h at edge %0d",
                   dq_out, cyc + 1, e.data, e.samp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] b,
                       input logic [12:0] a, input logic [15:0] d,
                       input logic mh, input logic ml);
    @(negedge clk);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    bank_addr = b;
    addr = a;
    dq_in = d;
    data_mask_high = mh;
    data_mask_low = ml;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cs_n = 1'b1;
      {ras_n, cas_n, we_n} = 3'b111;
      data_mask_high = 1'b0;
      data_mask_low = 1'b0;
    end
  endtask

  task automatic act(input logic [1:0] b, input logic [12:0] row);
    issue(3'b011, b, row, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] b, input logic [8:0] col,
                    input logic ap, input logic [15:0] exp,
                    input logic push);
    logic [12:0] a;
    exp_t e;
    a = {2'b00, ap, 1'b0, col};
    issue(3'b101, b, a, 16'h0, 1'b0, 1'b0);
    if (push) begin
      e.data = exp;
      e.samp = cyc + 1 + cl_m;
      q.push_back(e);
    end
  endtask

  task automatic wr(input logic [1:0] b, input logic [8:0] col,
                    input logic ap, input logic [15:0] d,
                    input logic mh, input logic ml);
    logic [12:0] a;
    a = {2'b00, ap, 1'b0, col};
    issue(3'b100, b, a, d, mh, ml);
  endtask

  task automatic pre_all();
    issue(3'b010, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic pre_bank(input logic [1:0] b);
    issue(3'b010, b, 13'h000, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic refc();
    issue(3'b001, 2'd0, 13'h000, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic mrs(input logic [12:0] a);
    issue(3'b000, 2'd0, a, 16'h0, 1'b0, 1'b0);
    cl_m = (a[6:4] == 3'd2) ? 2 : 3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dq_oe", 32'(dq_oe), 32'h0);
    check("rst_dq_out", 32'(dq_out), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_refresh", 32'(refresh_count), 32'h0);
    rst = 1'b0;
    idle(2);

    pre_all();
    refc();
    refc();
    mrs(13'h030);
    idle(1);
    check("init_ready", 32'(ready), 32'h1);
    check("init_refresh", 32'(refresh_count), 32'd2);
    check("init_err", 32'(err), 32'h0);

    act(2'd1, 13'h0005);
    wr(2'd1, 9'h012, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    act(2'd1, 13'h0005);
    rd(2'd1, 9'h012, 1'b1, 16'hBEEF, 1'b1);
    idle(6);

    act(2'd1, 13'h0005);
    wr(2'd1, 9'h012, 1'b0, 16'h1234, 1'b1, 1'b0);
    rd(2'd1, 9'h012, 1'b1, 16'hBE34, 1'b1);
    idle(6);

    act(2'd1, 13'h0005);
    wr(2'd1, 9'h013, 1'b0, 16'hCAFE, 1'b0, 1'b0);
    wr(2'd1, 9'h013, 1'b0, 16'h1111, 1'b0, 1'b1);
    pre_bank(2'd1);
    idle(2);

    act(2'd1, 13'h0005);
    rd(2'd1, 9'h012, 1'b1, 16'hBE34, 1'b1);
    mrs(13'h020);
    act(2'd1, 13'h0005);
    rd(2'd1, 9'h012, 1'b0, 16'hBE34, 1'b1);
    rd(2'd1, 9'h013, 1'b1, 16'h11FE, 1'b1);
    idle(6);

    mrs(13'h050);
    act(2'd1, 13'h0005);
    rd(2'd1, 9'h012, 1'b1, 16'hBE34, 1'b1);
    idle(6);

    act(2'd1, 13'h0005);
    rd(2'd1, 9'h013, 1'b1, 16'h11FE, 1'b1);
    refc();
    idle(6);
    check("pre_err", 32'(err), 32'h0);

    rd(2'd1, 9'h012, 1'b0, 16'hBE34, 1'b1);
    idle(6);
    check("err_set", 32'(err), 32'(EXP_ERR));
    act(2'd1, 13'h0005);
    rd(2'd1, 9'h013, 1'b1, 16'h11FE, 1'b1);
    idle(6);
    check("err_sticky", 32'(err), 32'(EXP_ERR));
    check("refresh_3", 32'(refresh_count), 32'd3);

    act(2'd1, 13'h0005);
    rd(2'd1, 9'h012, 1'b1, 16'h0, 1'b0);
    idle(1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_dq_oe", 32'(dq_oe), 32'h0);
    check("rst_mid_ready", 32'(ready), 32'h0);
    check("rst_mid_err", 32'(err), 32'h0);
    check("rst_mid_refresh", 32'(refresh_count), 32'h0);
    cl_m = 3;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(6);

    pre_all();
    mrs(13'h020);
    act(2'd1, 13'h0005);
    rd(2'd1, 9'h012, 1'b1, 16'h0, 1'b0);
    idle(1);
    @(posedge clk);
    #1;
    check("beat_before_rst", 32'(dq_oe), 32'h1);
    check("beat_data", 32'(dq_out), 32'hBE34);
    #1 rst = 1'b1;
    #1;
    check("async_drop_oe", 32'(dq_oe), 32'h0);
    check("async_drop_out", 32'(dq_out), 32'h0);
    cl_m = 3;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(6);

    check("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
